rv32i_multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath enables and muxes, including the immediate-generator select. Sits between the instruction register / branch comparator and the shared instruction/data memory port, and runs that port with a req/ready handshake.

---
 rtl/rv32i_multicycle_controller_pkg.sv | 96 +++++++++
 rtl/rv32i_opcode_decoder.sv | 39 +++
 rtl/rv32i_multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_rv32i_multicycle_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the multi-cycle RV32I control path:
//   - base opcode constants
//   - datapath select encodings (immediate generator, ALU, PC, writeback)
//   - instruction class latched by the controller in DECODE
//   - controller state enum
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Encoding shared with the immediate generator.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_RS1    = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_ZERO   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'b00,
        PC_ALU      = 2'b01,
        PC_ALU_JALR = 2'b10
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    typedef enum logic [3:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_OP,
        CLS_OP_IMM,
        CLS_LUI,
        CLS_AUIPC,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_RESET_WAIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } ctrl_state_t;

    // Immediate format of each class; register-only classes fall back to I.
    function automatic imm_sel_t class_imm_sel(input instr_class_t cls);
        imm_sel_t sel;
        case (cls)
            CLS_STORE:           sel = IMM_S;
            CLS_BRANCH:          sel = IMM_B;
            CLS_JAL:             sel = IMM_J;
            CLS_LUI, CLS_AUIPC:  sel = IMM_U;
            default:             sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv32i_opcode_decoder.sv
// -----------------------------------------------------------------------------
// rv32i_opcode_decoder
// Combinational classification of the 7-bit base opcode.
//   opcode      in  7  instruction register bits [6:0]
//   instr_class out 4  instr_class_t encoding of the instruction class
//   imm_sel     out 3  immediate format for that class
//   illegal     out 1  opcode is not a supported RV32I base opcode
// -----------------------------------------------------------------------------
module rv32i_opcode_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] instr_class,
    output logic [2:0] imm_sel,
    output logic       illegal
);

    instr_class_t w_class;

    always_comb begin
        case (opcode)
            OPC_LOAD:   w_class = CLS_LOAD;
            OPC_STORE:  w_class = CLS_STORE;
            OPC_OP:     w_class = CLS_OP;
            OPC_OP_IMM: w_class = CLS_OP_IMM;
            OPC_LUI:    w_class = CLS_LUI;
            OPC_AUIPC:  w_class = CLS_AUIPC;
            OPC_BRANCH: w_class = CLS_BRANCH;
            OPC_JAL:    w_class = CLS_JAL;
            OPC_JALR:   w_class = CLS_JALR;
            default:    w_class = CLS_ILLEGAL;
        endcase
    end

    assign instr_class = w_class;
    assign imm_sel     = class_imm_sel(w_class);
    assign illegal     = (w_class == CLS_ILLEGAL);

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// -----------------------------------------------------------------------------
// rv32i_multicycle_controller
// Main control FSM of the multi-cycle RV32I core. Steps each instruction
// through FETCH / DECODE / EXECUTE / MEM / WRITEBACK and runs the shared
// memory port with a req/ready handshake.
//   clk, reset                      clock, synchronous active-high reset
//   opcode, branch_taken, mem_ready from IR, comparator and memory
//   mem_req, mem_we, mem_addr_sel   memory port control
//   ir_write, pc_write, pc_sel      instruction register / PC update
//   imm_sel, alu_src_a/b, alu_op    immediate generator and ALU control
//   reg_write, wb_sel               register-file writeback
//   illegal_instr                   sticky trap flag (held in TRAP)
//   instr_done                      one-cycle retire pulse
// -----------------------------------------------------------------------------
module rv32i_multicycle_controller
    import rv32i_pkg::*;
#(
    parameter int RESET_STALL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       illegal_instr,
    output logic       instr_done
);

    localparam int          CNT_W       = (RESET_STALL > 1) ? $clog2(RESET_STALL) : 1;
    localparam ctrl_state_t RESET_STATE = (RESET_STALL == 0) ? ST_FETCH : ST_RESET_WAIT;

    ctrl_state_t       r_state;
    ctrl_state_t       w_next_state;
    instr_class_t      r_class;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [3:0]        w_dec_class;
    logic [2:0]        w_dec_imm_sel;
    logic              w_dec_illegal;
    logic              w_stall_done;

    rv32i_opcode_decoder u_decoder (
        .opcode      (opcode),
        .instr_class (w_dec_class),
        .imm_sel     (w_dec_imm_sel),
        .illegal     (w_dec_illegal)
    );

    assign w_stall_done = (r_stall_cnt == CNT_W'(RESET_STALL - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the class register is only loaded in DECODE so the
    // IR may change afterwards without disturbing the instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_stall_cnt <= '0;
            r_class     <= CLS_OP;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RESET_WAIT)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_state == ST_DECODE)
                r_class <= instr_class_t'(w_dec_class);
        end
    end

    // NOTE: every output and the next state get a default before the case so
    // no path leaves them unassigned (no latches), and the case is skipped
    // while reset is high so all outputs read 0 during reset.
    always_comb begin
        w_next_state  = r_state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = PC_PLUS4;
        imm_sel       = IMM_I;
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        illegal_instr = 1'b0;
        instr_done    = 1'b0;

        if (!reset) begin
            case (r_state)
                ST_RESET_WAIT: begin
                    if (RESET_STALL == 0 || w_stall_done)
                        w_next_state = ST_FETCH;
                end

                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_next_state = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    imm_sel      = w_dec_imm_sel;
                    w_next_state = w_dec_illegal ? ST_TRAP : ST_EXECUTE;
                end

                ST_EXECUTE: begin
                    imm_sel   = class_imm_sel(r_class);
                    alu_src_b = SRC_B_IMM;
                    case (r_class)
                        CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
                        CLS_OP: begin
                            alu_src_b    = SRC_B_RS2;
                            alu_op       = ALU_FUNCT;
                            w_next_state = ST_WRITEBACK;
                        end
                        CLS_OP_IMM: begin
                            alu_op       = ALU_FUNCT;
                            w_next_state = ST_WRITEBACK;
                        end
                        CLS_LUI: begin
                            alu_src_a    = SRC_A_ZERO;
                            w_next_state = ST_WRITEBACK;
                        end
                        CLS_AUIPC: begin
                            alu_src_a    = SRC_A_OLD_PC;
                            w_next_state = ST_WRITEBACK;
                        end
                        CLS_BRANCH: begin
                            // ALU forms the target; the comparator decides.
                            alu_src_a    = SRC_A_OLD_PC;
                            pc_write     = branch_taken;
                            pc_sel       = branch_taken ? PC_ALU : PC_PLUS4;
                            instr_done   = 1'b1;
                            w_next_state = ST_FETCH;
                        end
                        CLS_JAL: begin
                            alu_src_a    = SRC_A_OLD_PC;
                            pc_write     = 1'b1;
                            pc_sel       = PC_ALU;
                            w_next_state = ST_WRITEBACK;
                        end
                        CLS_JALR: begin
                            pc_write     = 1'b1;
                            pc_sel       = PC_ALU_JALR;
                            w_next_state = ST_WRITEBACK;
                        end
                        default: w_next_state = ST_TRAP;
                    endcase
                end

                ST_MEM: begin
                    // Address operands stay as in EXECUTE (rs1 + imm, ADD).
                    imm_sel      = class_imm_sel(r_class);
                    alu_src_b    = SRC_B_IMM;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (r_class == CLS_STORE);
                    if (mem_ready) begin
                        if (r_class == CLS_STORE) begin
                            instr_done   = 1'b1;
                            w_next_state = ST_FETCH;
                        end else begin
                            w_next_state = ST_WRITEBACK;
                        end
                    end
                end

                ST_WRITEBACK: begin
                    imm_sel    = class_imm_sel(r_class);
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    case (r_class)
                        CLS_LOAD:          wb_sel = WB_MEM;
                        CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                        default:           wb_sel = WB_ALU;
                    endcase
                    w_next_state = ST_FETCH;
                end

                ST_TRAP: illegal_instr = 1'b1;

                default: w_next_state = RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_rv32i_multicycle_controller
// Self-checking bench: the bench plays the memory (programmable wait states)
// and compares per-instruction observations against a reference model of
// instruction timing and control values derived from the instruction class.
// -----------------------------------------------------------------------------
module tb_rv32i_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0] pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [2:0] imm_sel;
    logic       reg_write, illegal_instr, instr_done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_instr = 0;

    rv32i_multicycle_controller #(.RESET_STALL(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .imm_sel       (imm_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .illegal_instr (illegal_instr),
        .instr_done    (instr_done)
    );

    always #5 clk = ~clk;

    wire [5:0]  strobes  = {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done};
    wire [20:0] all_outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel,
                            imm_sel, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
                            illegal_instr, instr_done};

    // Expected behaviour of one instruction, straight from the class rules.
    typedef struct packed {
        logic [2:0] imm;
        logic [3:0] base_cpi;
        logic       mem;
        logic       store;
        logic       wr;
        logic [1:0] wb;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       jump;
        logic       branch;
        logic [1:0] jsel;
    } exp_t;

    function automatic exp_t model(input logic [6:0] opc);
        exp_t e;
        e = '0;
        case (opc)
            7'b0000011: begin e.imm = 3'd0; e.base_cpi = 4'd5; e.mem = 1; e.wr = 1; e.wb = 2'b01; e.b = 2'b01; end
            7'b0100011: begin e.imm = 3'd1; e.base_cpi = 4'd4; e.mem = 1; e.store = 1; e.b = 2'b01; end
            7'b0110011: begin e.imm = 3'd0; e.base_cpi = 4'd4; e.wr = 1; e.op = 2'b10; end
            7'b0010011: begin e.imm = 3'd0; e.base_cpi = 4'd4; e.wr = 1; e.b = 2'b01; e.op = 2'b10; end
            7'b0110111: begin e.imm = 3'd4; e.base_cpi = 4'd4; e.wr = 1; e.a = 2'b10; e.b = 2'b01; end
            7'b0010111: begin e.imm = 3'd4; e.base_cpi = 4'd4; e.wr = 1; e.a = 2'b01; e.b = 2'b01; end
            7'b1100011: begin e.imm = 3'd2; e.base_cpi = 4'd3; e.branch = 1; e.a = 2'b01; e.b = 2'b01; e.jsel = 2'b01; end
            7'b1101111: begin e.imm = 3'd3; e.base_cpi = 4'd4; e.wr = 1; e.wb = 2'b10; e.a = 2'b01; e.b = 2'b01; e.jump = 1; e.jsel = 2'b01; end
            7'b1100111: begin e.imm = 3'd0; e.base_cpi = 4'd4; e.wr = 1; e.wb = 2'b10; e.b = 2'b01; e.jump = 1; e.jsel = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic string tg(input string s);
        return $sformatf("i%0d_op%b_%s", n_instr, opcode, s);
    endfunction

    // Runs one legal instruction from FETCH to retire. Entered and left on a
    // falling edge; fw / dw are the fetch / data wait-state counts.
    task automatic run_instr(input logic [6:0] opc, input int fw, input int dw, input logic taken);
        exp_t       e;
        int         exp_cyc, cyc, req_idx, cnt, fetch_done, done_cyc;
        int         n_ir, n_rw, rw_cyc, n_pcx, n_we, imm_bad, hs_bad, wait_bad, ill_bad;
        logic       exp_pcx, done, q_addr, q_we, ex_pcw;
        logic [1:0] wb_at_rw, ex_pcsel, ex_a, ex_b, ex_op;

        e = model(opc);
        exp_cyc = int'(e.base_cpi) + fw + (e.mem ? dw : 0);
        exp_pcx = e.jump || (e.branch && taken);
        cyc = 0; req_idx = 0; cnt = 0; fetch_done = 1000; done_cyc = 0;
        n_ir = 0; n_rw = 0; rw_cyc = 0; n_pcx = 0; n_we = 0;
        imm_bad = 0; hs_bad = 0; wait_bad = 0; ill_bad = 0;
        done = 0; q_addr = 0; q_we = 0; ex_pcw = 0;
        wb_at_rw = '0; ex_pcsel = '0; ex_a = '1; ex_b = '1; ex_op = '1;
        n_instr++;
        opcode = opc;
        branch_taken = taken;

        while (!done && cyc < 64) begin
            cyc++;
            if (mem_req) mem_ready = (cnt == ((req_idx == 0) ? fw : dw));
            else         mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (mem_req) begin
                if (cnt == 0) begin
                    q_addr = mem_addr_sel;
                    q_we   = mem_we;
                    if (mem_addr_sel !== (req_idx != 0) || mem_we !== (req_idx == 1 && e.store))
                        hs_bad++;
                end else if (mem_addr_sel !== q_addr || mem_we !== q_we) begin
                    hs_bad++;
                end
                if (!mem_ready && (pc_write || reg_write || ir_write)) wait_bad++;
            end else if (mem_we) begin
                hs_bad++;
            end
            if (mem_req && mem_ready && req_idx == 0) fetch_done = cyc;
            if (ir_write) begin
                n_ir++;
                if (pc_write !== 1'b1 || pc_sel !== 2'b00) hs_bad++;
            end
            if (pc_write && !ir_write) n_pcx++;
            if (mem_we) n_we++;
            if (reg_write) begin n_rw++; rw_cyc = cyc; wb_at_rw = wb_sel; end
            if (illegal_instr) ill_bad++;
            if (cyc > fetch_done && imm_sel !== e.imm) imm_bad++;
            if (cyc == fetch_done + 2) begin
                ex_a = alu_src_a; ex_b = alu_src_b; ex_op = alu_op;
                ex_pcw = pc_write; ex_pcsel = pc_sel;
            end
            if (instr_done) begin done = 1; done_cyc = cyc; end
            if (mem_req) begin
                if (mem_ready) begin req_idx++; cnt = 0; end
                else cnt++;
            end
            @(negedge clk);
        end

        check(tg("retired"), 32'(done), 1);
        check(tg("cycles"), done_cyc, exp_cyc);
        check(tg("mem_requests"), req_idx, e.mem ? 2 : 1);
        check(tg("ir_writes"), n_ir, 1);
        check(tg("reg_writes"), n_rw, e.wr ? 1 : 0);
        if (e.wr) begin
            check(tg("reg_write_cycle"), rw_cyc, exp_cyc);
            check(tg("wb_sel"), 32'(wb_at_rw), 32'(e.wb));
        end
        check(tg("mem_we_cycles"), n_we, e.store ? dw + 1 : 0);
        check(tg("exec_alu"), {ex_a, ex_b, ex_op}, {e.a, e.b, e.op});
        check(tg("exec_pc_write"), 32'(ex_pcw), 32'(exp_pcx));
        check(tg("extra_pc_writes"), n_pcx, exp_pcx ? 1 : 0);
        if (exp_pcx) check(tg("exec_pc_sel"), 32'(ex_pcsel), 32'(e.jsel));
        check(tg("imm_sel_bad_cycles"), imm_bad, 0);
        check(tg("handshake_bad"), hs_bad, 0);
        check(tg("strobe_in_wait"), wait_bad, 0);
        check(tg("illegal_seen"), ill_bad, 0);
    endtask

    // Holds reset for ncyc cycles, releases it, and checks the stall (2 idle
    // cycles) before the first fetch request. Leaves the DUT in FETCH.
    task automatic reset_pulse(input int ncyc, input logic ready_in_reset);
        for (int i = 0; i < ncyc; i++) begin
            reset = 1'b1;
            mem_ready = ready_in_reset;
            opcode = 7'($urandom);
            #1;
            check($sformatf("reset_outs_zero_%0d", i), 32'(all_outs), 0);
            @(negedge clk);
        end
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mem_ready = (c < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (c < 3) begin
                check($sformatf("stall_outs_zero_c%0d", c), 32'(all_outs), 0);
            end else begin
                check("first_fetch_req", 32'(mem_req), 1);
                check("first_fetch_addr_sel", 32'(mem_addr_sel), 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic run_illegal(input int fw);
        int   cnt, guard;
        logic fetched;
        cnt = 0; guard = 0; fetched = 0;
        n_instr++;
        opcode = 7'b1111111;
        while (!fetched && guard < 64) begin
            guard++;
            mem_ready = mem_req ? (cnt == fw) : 1'b0;
            #1;
            if (mem_req && mem_ready) fetched = 1;
            else cnt++;
            @(negedge clk);
        end
        check(tg("illegal_fetched"), 32'(fetched), 1);
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check(tg("decode_no_trap_yet"), {illegal_instr, strobes}, 0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            #1;
            check(tg($sformatf("trap_hold_%0d", i)), {illegal_instr, strobes}, {1'b1, 6'b0});
            @(negedge clk);
        end
    endtask

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                                  7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};

    initial begin
        @(negedge clk);
        reset_pulse(3, 1'b1);

        // Directed cases from the instruction-level timing rules.
        run_instr(7'b0010011, 0, 0, 1'b0);          // ADDI, zero wait
        run_instr(7'b0010011, 3, 0, 1'b1);          // ADDI, 3 fetch waits
        run_instr(7'b0000011, 0, 2, 1'b0);          // LW, 2 data waits
        run_instr(7'b0100011, 0, 2, 1'b1);          // SW, 2 data waits
        run_instr(7'b1100011, 0, 0, 1'b1);          // BEQ taken
        run_instr(7'b1100011, 1, 0, 1'b0);          // BEQ not taken
        run_instr(7'b1101111, 0, 0, 1'b0);          // JAL
        run_instr(7'b1100111, 2, 0, 1'b1);          // JALR

        for (int i = 0; i < 60; i++)
            run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        run_illegal(1);
        reset_pulse(1, 1'b1);                       // leave TRAP

        // Reset while a fetch is stalled: request is abandoned.
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b0;
            #1;
            check($sformatf("fetch_wait_req_%0d", i), 32'(mem_req), 1);
            @(negedge clk);
        end
        reset_pulse(1, 1'b1);
        run_instr(7'b0010011, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
